// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_pkg;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_HOLD   = 2'd0,
      PC_SEQ    = 2'd1,
      PC_TARGET = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/pc_register.sv
// Program counter with its next-PC mux: hold, sequential step, or redirect target.
module pc_register
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  pc_sel_e     pc_sel,
   input  logic [31:0] target,
   output logic [31:0] pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      case (pc_sel)
         PC_SEQ:    pc_d = pc_q + PC_STEP;
         PC_TARGET: pc_d = target;
         default:   pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: boot/run/fault FSM feeding a valid/ready fetch-decode register.
// Optional build macro FETCH_COUNT_EN adds a counter of instructions accepted by decode.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          MEM_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] A,
   input  logic [31:0] RD,
   input  logic        Redirect,
   input  logic [31:0] Target,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   input  logic        ReadyD,
   output logic        FetchFault,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);

   fetch_state_e state_q, state_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic         fault_q, fault_d;
   pc_sel_e      pc_sel;
   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic         advance;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .reset  (reset),
      .pc_sel (pc_sel),
      .target (Target),
      .pc     (pc)
   );

   assign pc_plus4 = pc + PC_STEP;
   assign advance  = (!valid_q || ReadyD) && !Redirect;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      fault_d = fault_q;
      pc_sel  = PC_HOLD;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (Redirect) begin
               // A misaligned target faults without ever reaching the PC.
               valid_d = 1'b0;
               if (Target[1:0] != 2'b00) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end else begin
                  pc_sel = PC_TARGET;
               end
            end else if (advance) begin
               if (pc >= MEM_LIMIT) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
                  valid_d = 1'b0;
               end else begin
                  instr_d = RD;
                  pc4_d   = pc_plus4;
                  valid_d = 1'b1;
                  pc_sel  = PC_SEQ;
               end
            end
         end
         FAULT: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = BOOT;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] count_q, count_d;
   logic        transfer;

   // A hand-off that coincides with a redirect still counts; only the next entry is flushed.
   assign transfer = valid_q && ReadyD;

   always_comb begin
      count_d = count_q;
      if (transfer) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign FetchCount = count_q;
`else
   assign FetchCount = '0;
`endif

   assign A          = pc;
   assign InstrD     = instr_q;
   assign PCPlus4D   = pc4_q;
   assign ValidD     = valid_q;
   assign FetchFault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] RD;
   logic        Redirect;
   logic [31:0] Target;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        ReadyD;
   logic        FetchFault;
   logic [31:0] FetchCount;

   int n_total = 0;
   int n_bad   = 0;
   int exp_cnt = 0;
   logic cur_v = 1'b0;

   typedef struct {
      logic        redir;
      logic [31:0] tgt;
      logic        rdy;
      logic [31:0] a;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        fault;
   } vec_t;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .MEM_DEPTH (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .A          (A),
      .RD         (RD),
      .Redirect   (Redirect),
      .Target     (Target),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .ReadyD     (ReadyD),
      .FetchFault (FetchFault),
      .FetchCount (FetchCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'hC0DE_0000 ^ addr;
   endfunction

   assign RD = mem_word(A);

   function automatic vec_t mk(input logic redir, input logic [31:0] tgt, input logic rdy,
                               input logic [31:0] a, input logic v, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic fault);
      vec_t r;
      r.redir = redir; r.tgt = tgt; r.rdy = rdy; r.a = a;
      r.v = v; r.instr = instr; r.pc4 = pc4; r.fault = fault;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef FETCH_COUNT_EN
      return 32'(exp_cnt);
`else
      return 32'd0;
`endif
   endfunction

   task automatic check_reset(input string tag);
      check({tag, ".A"},          A,          32'h0);
      check({tag, ".ValidD"},     {31'd0, ValidD},     32'h0);
      check({tag, ".InstrD"},     InstrD,     32'h0);
      check({tag, ".PCPlus4D"},   PCPlus4D,   32'h0);
      check({tag, ".FetchFault"}, {31'd0, FetchFault}, 32'h0);
      check({tag, ".FetchCount"}, FetchCount, 32'h0);
      $display("%s: A=%h V=%b I=%h P=%h F=%b C=%0d", tag, A, ValidD, InstrD, PCPlus4D,
               FetchFault, FetchCount);
   endtask

   task automatic apply(input vec_t v, input string tag);
      Redirect = v.redir;
      Target   = v.tgt;
      ReadyD   = v.rdy;
      if (cur_v && v.rdy) exp_cnt++;
      @(posedge clk);
      #1;
      check({tag, ".A"},          A,                   v.a);
      check({tag, ".ValidD"},     {31'd0, ValidD},     {31'd0, v.v});
      check({tag, ".FetchFault"}, {31'd0, FetchFault}, {31'd0, v.fault});
      check({tag, ".FetchCount"}, FetchCount,          exp_count());
      if (v.v) begin
         check({tag, ".InstrD"},   InstrD,   v.instr);
         check({tag, ".PCPlus4D"}, PCPlus4D, v.pc4);
      end
      cur_v = v.v;
      $display("%s: A=%h V=%b I=%h P=%h F=%b C=%0d", tag, A, ValidD, InstrD, PCPlus4D,
               FetchFault, FetchCount);
   endtask

   vec_t tbl[14];
   vec_t seq2[6];

   initial begin
      // Boot, 3-cycle stall, redirect to 16 with a coincident hand-off, run to A=32, fault.
      tbl[0]  = mk(0, 0,  1, 32'd0,  0, 0,            0,      0);
      tbl[1]  = mk(0, 0,  1, 32'd4,  1, mem_word(0),  32'd4,  0);
      tbl[2]  = mk(0, 0,  0, 32'd4,  1, mem_word(0),  32'd4,  0);
      tbl[3]  = mk(0, 0,  0, 32'd4,  1, mem_word(0),  32'd4,  0);
      tbl[4]  = mk(0, 0,  0, 32'd4,  1, mem_word(0),  32'd4,  0);
      tbl[5]  = mk(0, 0,  1, 32'd8,  1, mem_word(4),  32'd8,  0);
      tbl[6]  = mk(1, 16, 1, 32'd16, 0, 0,            0,      0);
      tbl[7]  = mk(0, 0,  1, 32'd20, 1, mem_word(16), 32'd20, 0);
      tbl[8]  = mk(0, 0,  1, 32'd24, 1, mem_word(20), 32'd24, 0);
      tbl[9]  = mk(0, 0,  1, 32'd28, 1, mem_word(24), 32'd28, 0);
      tbl[10] = mk(0, 0,  1, 32'd32, 1, mem_word(28), 32'd32, 0);
      tbl[11] = mk(0, 0,  0, 32'd32, 1, mem_word(28), 32'd32, 0);
      tbl[12] = mk(0, 0,  1, 32'd32, 0, 0,            0,      1);
      tbl[13] = mk(1, 8,  1, 32'd32, 0, 0,            0,      1);

      // Misaligned redirect from A=8: fault with A frozen, later redirects ignored.
      seq2[0] = mk(0, 0,  1, 32'd0, 0, 0,           0,     0);
      seq2[1] = mk(0, 0,  1, 32'd4, 1, mem_word(0), 32'd4, 0);
      seq2[2] = mk(0, 0,  1, 32'd8, 1, mem_word(4), 32'd8, 0);
      seq2[3] = mk(1, 18, 0, 32'd8, 0, 0,           0,     1);
      seq2[4] = mk(1, 16, 1, 32'd8, 0, 0,           0,     1);
      seq2[5] = mk(0, 0,  1, 32'd8, 0, 0,           0,     1);

      reset    = 1'b1;
      Redirect = 1'b0;
      Target   = 32'h0;
      ReadyD   = 1'b0;
      @(posedge clk);
      #1;
      check_reset("reset0");
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset between clock edges while faulted.
      #2;
      reset = 1'b1;
      #1;
      exp_cnt = 0;
      cur_v   = 1'b0;
      check_reset("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         apply(seq2[i], $sformatf("mis%0d", i));
      end

      // Reset in the middle of a stall clears everything immediately.
      reset = 1'b1;
      #1;
      exp_cnt = 0;
      cur_v   = 1'b0;
      check_reset("reset_fault");
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(mk(0, 0, 1, 32'd0, 0, 0,           0,     0), "stl0");
      apply(mk(0, 0, 0, 32'd4, 1, mem_word(0), 32'd4, 0), "stl1");
      apply(mk(0, 0, 0, 32'd4, 1, mem_word(0), 32'd4, 0), "stl2");
      #2;
      reset = 1'b1;
      #1;
      exp_cnt = 0;
      cur_v   = 1'b0;
      check_reset("reset_stall");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
